// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel pipeline output path.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IDX_HI,
    IDX_LO,
    PAYLOAD,
    CSUM
  } line_framer_state_t;

  localparam int unsigned HDR_BYTES    = 3;
  localparam int unsigned BYTE_W       = 8;
  localparam logic [7:0]  LF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/line_framer_if.sv
// Byte-wide valid/ready stream used on both sides of the line framer.
interface line_framer_if;
  import sobel_pkg::*;

  logic [BYTE_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/elastic.sv
// Single-entry output register; accepts a new word whenever empty or being drained.
module elastic #(
  parameter int unsigned WIDTH_P = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [WIDTH_P-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i
);

  assign ready_o = ~valid_o | ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (ready_o) begin
      valid_o <= valid_i;
      if (valid_i) data_o <= data_i;
    end
  end

endmodule

// File: rtl/line_framer.sv
// Wraps each line of payload bytes as: sync, 16-bit line index (MSB first),
// payload, XOR checksum.
module line_framer
  import sobel_pkg::*;
#(
  parameter int unsigned LINE_BYTES_P  = 1920,
  parameter int unsigned FRAME_LINES_P = 480,
  parameter logic [7:0]  SYNC_BYTE_P   = LF_SYNC_BYTE
) (
  input  logic          clk_i,
  input  logic          rst_i,
  line_framer_if.slave  in_s,
  line_framer_if.master out_m,
  output logic          frame_done_o
);

  localparam int unsigned     CNT_W    = $clog2(LINE_BYTES_P + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_BYTES_P - 1);
  localparam logic [15:0]     IDX_LAST = 16'(FRAME_LINES_P - 1);

  line_framer_state_t state_q, state_d;
  logic [15:0]        line_idx_q, line_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         csum_q, csum_d;
  logic               frame_done_d;
  logic               load_ok;
  logic               load;
  logic [7:0]         load_byte;

  // Next-state, byte mux and input handshake
  always_comb begin
    state_d      = state_q;
    line_idx_d   = line_idx_q;
    cnt_d        = cnt_q;
    csum_d       = csum_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    load_byte    = '0;
    in_s.ready   = 1'b0;
    case (state_q)
      IDLE: begin
        // header only starts once payload is waiting; that byte stays on the input
        if (in_s.valid && load_ok) begin
          load      = 1'b1;
          load_byte = SYNC_BYTE_P;
          state_d   = IDX_HI;
        end
      end
      IDX_HI: begin
        if (load_ok) begin
          load      = 1'b1;
          load_byte = line_idx_q[15:8];
          state_d   = IDX_LO;
        end
      end
      IDX_LO: begin
        if (load_ok) begin
          load      = 1'b1;
          load_byte = line_idx_q[7:0];
          cnt_d     = '0;
          csum_d    = '0;
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        in_s.ready = load_ok;
        if (in_s.valid && load_ok) begin
          load      = 1'b1;
          load_byte = in_s.data;
          csum_d    = csum_q ^ in_s.data;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = CSUM;
        end
      end
      CSUM: begin
        if (load_ok) begin
          load      = 1'b1;
          load_byte = csum_q;
          state_d   = IDLE;
          if (line_idx_q == IDX_LAST) begin
            line_idx_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            line_idx_d = line_idx_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      line_idx_q   <= '0;
      cnt_q        <= '0;
      csum_q       <= '0;
      frame_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_idx_q   <= line_idx_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      frame_done_o <= frame_done_d;
    end
  end

  elastic #(.WIDTH_P(8)) u_out_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (load_byte),
    .valid_i (load),
    .ready_o (load_ok),
    .data_o  (out_m.data),
    .valid_o (out_m.valid),
    .ready_i (out_m.ready)
  );

endmodule

// File: tb/tb_line_framer.sv
// Randomized bench for line_framer: two configurations checked against a
// position-based packet model (header/payload/checksum derived from accepted bytes).
module tb_line_framer;

  localparam int LA = 4;
  localparam int FA = 2;
  localparam int LB = 1;
  localparam int FB = 300;
  localparam int CAP = 2048;
  localparam int PAYMAX = 4096;

  logic            clk;
  logic [1:0]      rst, vi, ri, vo, ro, fd;
  logic [1:0][7:0] di, dout;

  line_framer_if ia_in ();
  line_framer_if ia_out ();
  line_framer_if ib_in ();
  line_framer_if ib_out ();

  assign ia_in.valid  = vi[0];
  assign ia_in.data   = di[0];
  assign ia_out.ready = ri[0];
  assign ib_in.valid  = vi[1];
  assign ib_in.data   = di[1];
  assign ib_out.ready = ri[1];
  assign vo   = {ib_out.valid, ia_out.valid};
  assign ro   = {ib_in.ready, ia_in.ready};
  assign dout = {ib_out.data, ia_out.data};

  logic fd_a, fd_b;
  assign fd = {fd_b, fd_a};

  line_framer #(.LINE_BYTES_P(LA), .FRAME_LINES_P(FA)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .in_s(ia_in), .out_m(ia_out), .frame_done_o(fd_a));

  line_framer #(.LINE_BYTES_P(LB), .FRAME_LINES_P(FB)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .in_s(ib_in), .out_m(ib_out), .frame_done_o(fd_b));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state per DUT
  int         out_cnt[2], pay_n[2], fd_cnt[2], send_left[2], vld_pol[2], rdy_pol[2];
  logic [1:0] acc_last, inc_mode, tog;
  logic [7:0] nxt[2];
  logic [7:0] pay[2][PAYMAX];
  logic [7:0] cap[2][CAP];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lb_of(input int d);
    return (d == 0) ? LA : LB;
  endfunction

  function automatic int fl_of(input int d);
    return (d == 0) ? FA : FB;
  endfunction

  // Expected byte at output position p since the last reset
  function automatic logic [7:0] exp_byte(input int d, input int p);
    int lb, pl, line, off, idx, base;
    logic [7:0] x;
    lb   = lb_of(d);
    pl   = lb + 4;
    line = p / pl;
    off  = p % pl;
    idx  = line % fl_of(d);
    base = line * lb;
    if (off == 0) return 8'hA5;
    if (off == 1) return 8'(idx >> 8);
    if (off == 2) return 8'(idx);
    if (off < lb + 3) begin
      if (base + off - 3 >= pay_n[d]) return 8'bx;
      return pay[d][base + off - 3];
    end
    if (base + lb > pay_n[d]) return 8'bx;
    x = 8'h00;
    for (int i = 0; i < lb; i++) x = x ^ pay[d][base + i];
    return x;
  endfunction

  task automatic step(input int d);
    logic nv;
    @(negedge clk);
    if (vo[d]) begin
      check($sformatf("d%0d_byte%0d", d, out_cnt[d]), 16'(dout[d]), 16'(exp_byte(d, out_cnt[d])));
      if (out_cnt[d] < CAP) cap[d][out_cnt[d]] = dout[d];
    end
    if (fd[d]) begin
      fd_cnt[d]++;
      check($sformatf("d%0d_frame_done_pos%0d", d, out_cnt[d]),
            16'(vo[d] && ((out_cnt[d] + 1) % (fl_of(d) * (lb_of(d) + 4)) == 0)), 16'd1);
    end
    case (rdy_pol[d])
      0:       ri[d] = 1'b0;
      1:       ri[d] = 1'b1;
      default: ri[d] = 1'($urandom_range(0, 1));
    endcase
    tog[d] = ~tog[d];
    if (!(vi[d] && !acc_last[d])) begin
      case (vld_pol[d])
        0:       nv = 1'b1;
        1:       nv = tog[d];
        default: nv = 1'($urandom_range(0, 1));
      endcase
      if (send_left[d] == 0) nv = 1'b0;
      vi[d] = nv;
      if (nv) begin
        if (inc_mode[d]) begin
          di[d]  = nxt[d];
          nxt[d] = nxt[d] + 8'd1;
        end else begin
          di[d] = 8'($urandom);
        end
      end
    end
    #1;
    if (vo[d] && !ri[d]) check($sformatf("d%0d_stall_ready", d), 16'(ro[d]), 16'd0);
    if (vo[d] && ri[d]) out_cnt[d]++;
    acc_last[d] = vi[d] && ro[d];
    if (acc_last[d]) begin
      if (pay_n[d] < PAYMAX) pay[d][pay_n[d]] = di[d];
      pay_n[d]++;
      send_left[d]--;
    end
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d] = 1'b1;
    vi[d]  = 1'b0;
    ri[d]  = 1'b1;
    #1;
    check($sformatf("d%0d_rst_valid", d), 16'(vo[d]), 16'd0);
    check($sformatf("d%0d_rst_data", d), 16'(dout[d]), 16'd0);
    check($sformatf("d%0d_rst_ready", d), 16'(ro[d]), 16'd0);
    check($sformatf("d%0d_rst_fdone", d), 16'(fd[d]), 16'd0);
    @(negedge clk);
    rst[d]       = 1'b0;
    out_cnt[d]   = 0;
    pay_n[d]     = 0;
    fd_cnt[d]    = 0;
    send_left[d] = 0;
    acc_last[d]  = 1'b0;
  endtask

  task automatic drain(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (out_cnt[d] < target && n < budget) begin
      step(d);
      n++;
    end
    check($sformatf("d%0d_drain", d), 16'(out_cnt[d]), 16'(target));
  endtask

  task automatic setup(input int d, input int bytes, input int vp, input int rp, input logic inc);
    send_left[d] = bytes;
    vld_pol[d]   = vp;
    rdy_pol[d]   = rp;
    inc_mode[d]  = inc;
  endtask

  logic [7:0] pkt1[8];
  logic [7:0] hdr[3];
  int         pn;

  initial begin
    clk = 1'b0;
    rst = 2'b11;
    vi  = '0;
    ri  = '1;
    di  = '0;
    acc_last = '0;
    inc_mode = '0;
    tog      = '0;
    for (int d = 0; d < 2; d++) begin
      out_cnt[d] = 0; pay_n[d] = 0; fd_cnt[d] = 0; send_left[d] = 0;
      vld_pol[d] = 0; rdy_pol[d] = 1; nxt[d] = 8'h01;
    end
    do_reset(0);
    do_reset(1);

    // Full-rate, three lines of 01,02,03,...
    nxt[0] = 8'h01;
    setup(0, 3 * LA, 0, 1, 1'b1);
    repeat (3 * (LA + 4) + 1) step(0);
    check("a_throughput", 16'(out_cnt[0]), 16'(3 * (LA + 4)));
    check("a_fdone_count", 16'(fd_cnt[0]), 16'd1);
    pkt1 = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    for (int i = 0; i < 8; i++) check($sformatf("a_pkt1_%0d", i), 16'(cap[0][i]), 16'(pkt1[i]));
    hdr = '{8'hA5, 8'h00, 8'h01};
    for (int i = 0; i < 3; i++) check($sformatf("a_l2hdr_%0d", i), 16'(cap[0][8 + i]), 16'(hdr[i]));
    hdr = '{8'hA5, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) check($sformatf("a_l3hdr_%0d", i), 16'(cap[0][16 + i]), 16'(hdr[i]));

    // Output stall while the index-low byte is held
    do_reset(0);
    setup(0, LA, 0, 1, 1'b0);
    repeat (3) step(0);
    pn = pay_n[0];
    rdy_pol[0] = 0;
    repeat (5) begin
      step(0);
      check("stall_data", 16'(dout[0]), 16'h00);
      check("stall_valid", 16'(vo[0]), 16'd1);
    end
    check("stall_consumed", 16'(pay_n[0]), 16'(pn));
    rdy_pol[0] = 2;
    drain(0, LA + 4, 200);

    // Toggling input valid with random output ready
    do_reset(0);
    setup(0, 3 * LA, 1, 2, 1'b0);
    drain(0, 3 * (LA + 4), 2000);
    check("tog_fdone_count", 16'(fd_cnt[0]), 16'd1);

    // Reset after two payload bytes
    do_reset(0);
    setup(0, LA, 0, 1, 1'b0);
    begin
      int n;
      n = 0;
      while (pay_n[0] < 2 && n < 50) begin
        step(0);
        n++;
      end
    end
    check("mid_accepted", 16'(pay_n[0]), 16'd2);
    @(negedge clk);
    vi[0] = 1'b0;
    ri[0] = 1'b0;
    #1;
    check("mid_valid_before_rst", 16'(vo[0]), 16'd1);
    do_reset(0);
    setup(0, LA, 2, 2, 1'b0);
    drain(0, LA + 4, 500);
    check("mid_fdone_count", 16'(fd_cnt[0]), 16'd0);

    // Long random run, five frames
    do_reset(0);
    setup(0, 10 * LA, 2, 2, 1'b0);
    drain(0, 10 * (LA + 4), 3000);
    check("rand_fdone_count", 16'(fd_cnt[0]), 16'd5);

    // One-byte lines, 300-line frame, index crossing 255 and wrapping
    setup(1, 302, 0, 1, 1'b0);
    repeat (302 * (LB + 4) + 1) step(1);
    check("b_throughput", 16'(out_cnt[1]), 16'(302 * (LB + 4)));
    check("b_fdone_count", 16'(fd_cnt[1]), 16'd1);
    hdr = '{8'hA5, 8'h01, 8'h00};
    for (int i = 0; i < 3; i++) check($sformatf("b_l257hdr_%0d", i), 16'(cap[1][256 * 5 + i]), 16'(hdr[i]));
    hdr = '{8'hA5, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) check($sformatf("b_l301hdr_%0d", i), 16'(cap[1][300 * 5 + i]), 16'(hdr[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_framer.md
# line_framer

Wraps the processed byte stream in per-line packets before it reaches the UART transmitter, so the host can resynchronise to line boundaries and detect corrupted lines. It sits directly downstream of the 24→8 RGB unpacker and directly upstream of the UART TX stream input. Each line of `LINE_BYTES_P` payload bytes is emitted as a sync byte, a 16-bit line index (MSB first), the payload unchanged, and an XOR checksum byte.

## Interface
Parameters:
- `LINE_BYTES_P`, default 1920: payload bytes per line (640 pixels × 3 bytes); must be ≥ 1.
- `FRAME_LINES_P`, default 480: lines per frame; range 1..65536.
- `SYNC_BYTE_P`, default 8'hA5: first byte of every packet.

Ports:
- `clk_i`  in  1: core clock.
- `rst_i`  in  1: reset; one clock, asynchronous, active-high.
- `data_i`  in  8: payload byte from the unpacker.
- `valid_i`  in  1: `data_i` valid.
- `ready_o`  out  1: block accepts `data_i` this cycle.
- `data_o`  out  8: framed byte to UART TX.
- `valid_o`  out  1: `data_o` valid.
- `ready_i`  in  1: UART TX accepts `data_o`.
- `frame_done_o`  out  1: one-cycle pulse when the checksum byte of the last line of a frame is loaded.

## Operation
- Output register: holds `data_o` and `valid_o`. It can load in a cycle when `load_ok = ~valid_o | ready_i`.
- States: IDLE, IDX_HI, IDX_LO, PAYLOAD, CSUM.
  - IDLE: the header is not started until payload exists. When `valid_i & load_ok`, load `SYNC_BYTE_P` → IDX_HI. The input byte is not consumed.
  - IDX_HI: when `load_ok`, load `line_idx[15:8]` → IDX_LO.
  - IDX_LO: when `load_ok`, load `line_idx[7:0]`; clear the byte counter and `csum` → PAYLOAD.
  - PAYLOAD: `ready_o = load_ok`. On `valid_i & ready_o`: load `data_i`, `csum ^= data_i`, and increment the counter. The byte that makes the count `LINE_BYTES_P` moves the FSM → CSUM.
  - CSUM: when `load_ok`, load `csum` (the final payload byte is included) → IDLE.
    - `line_idx` increments, wrapping to 0 after `FRAME_LINES_P-1`.
    - On that wrap, `frame_done_o` = 1 for that cycle.
- `ready_o` = 0 in every state except PAYLOAD.
- No bubbles are inserted by the block itself: each header, payload, or checksum byte loads on the first cycle it is eligible.
- `line_idx` is 16 bits, zero-extended. The byte counter is `$clog2(LINE_BYTES_P+1)` bits.

## Timing
- Reset values: `valid_o`=0, `data_o`=8'h00, `ready_o`=0, `frame_done_o`=0. FSM = IDLE, `line_idx`=0, `csum`=0, counter=0.
- Latency: an accepted input byte appears on `data_o` the next cycle. The sync byte appears one cycle after the first `valid_i` seen in IDLE, when `load_ok`.
- Throughput: 1 byte/cycle sustained. Per line: `LINE_BYTES_P + 4` output bytes.
- Stall on the output side: while `valid_o & ~ready_i`, `data_o` holds stable, the FSM holds, and `ready_o`=0.
- Input gaps in PAYLOAD: the FSM waits; the checksum and ordering are unaffected.
- Simultaneous consume and load: when `ready_i` is high and a new byte is eligible in the same cycle, the register reloads and `valid_o` stays 1.
- `LINE_BYTES_P`=1: the first accepted byte moves the FSM directly → CSUM.
- Reset mid-packet: everything returns to reset values immediately and any partial packet is dropped. The next packet starts with line index 0.
- `frame_done_o` is registered and not gated by `ready_i` beyond the load condition.

## Structure
- Shared package `sobel_pkg` holds:
  - the `line_framer_state_t` enum (IDLE, IDX_HI, IDX_LO, PAYLOAD, CSUM);
  - `HDR_BYTES = 3`;
  - the default sync byte constant.
- One sub-module is natural: the existing `elastic` (`WIDTH_P=8`) serves as the output register.
  - Its `ready_o` is `load_ok`.
  - A byte multiplexer selects the sync, index-high, index-low, payload, or checksum byte into it.
- Remaining logic: FSM, counter, `csum`, `line_idx`. Estimated 150–250 lines.

## Test plan
- `LINE_BYTES_P`=4, `FRAME_LINES_P`=2, `ready_i`=1. Input 01 02 03 04 → output A5 00 00 01 02 03 04 04.
- Same configuration, three lines.
  - Line 2 header is A5 00 01.
  - `frame_done_o` pulses once, when the line-2 checksum loads.
  - Line 3 header is A5 00 00.
- Hold `ready_i`=0 for 5 cycles while `data_o`=00 (IDX_LO). Expected: `data_o` is stable at 00, `valid_o`=1, `ready_o`=0, and no input is consumed.
- Toggle `valid_i` every other cycle during the payload, with random `ready_i`. Expected: the payload is in order, there are no duplicates, and the checksum equals the XOR of the payload.
- Assert `rst_i` after 2 payload bytes. Expected:
  - `valid_o`=0 immediately;
  - the next packet is A5 00 00 followed by fresh payload;
  - its checksum covers only the new bytes.
- `FRAME_LINES_P`=300, `LINE_BYTES_P`=1. Expected: the 257th line header is A5 01 00, and the line after index 299 is A5 00 00.
